serial_digit_loader: RTL and testbench

Upstream stage of the BCD display decoder. Assembles a 4-bit digit from a bit-serial input clocked by a strobe (button or slow external source), then presents it on A, B, C, D with a `ready` window for the decoder. The loader does no range check; codes 1010–1111 pass through unchanged, and the decoder flags them.

---
 rtl/serial_digit_pkg.sv | 18 +
 rtl/strobe_conditioner.sv | 73 +++++++
 rtl/serial_digit_loader.sv | 146 ++++++++++++++
 tb/tb_serial_digit_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_digit_pkg.sv
// Shared state type, widths and a counter-width helper for the serial digit loader.
package serial_digit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } loader_state_t;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned BIT_COUNT_W = 3;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strobe_conditioner.sv
// Synchronises the serial strobe and data, optionally debounces the strobe, and emits a
// one-cycle capture pulse per rising edge. Debounce is built when SERIAL_LOADER_DEBOUNCE_EN is defined.
module strobe_conditioner
  import serial_digit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_bit_strobe,
  input  logic i_bit_in,
  output logic o_capture,
  output logic o_bit
);

  logic r_strb_meta;
  logic r_strb_sync;
  logic r_bit_meta;
  logic r_bit_sync;
  logic r_bit_q;
  logic r_level_prev;
  logic r_capture;
  logic w_level;

  // The data path carries one extra stage so the bit lines up with the registered pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_strb_meta  <= 1'b0;
      r_strb_sync  <= 1'b0;
      r_bit_meta   <= 1'b0;
      r_bit_sync   <= 1'b0;
      r_bit_q      <= 1'b0;
      r_level_prev <= 1'b0;
      r_capture    <= 1'b0;
    end else begin
      r_strb_meta  <= i_bit_strobe;
      r_strb_sync  <= r_strb_meta;
      r_bit_meta   <= i_bit_in;
      r_bit_sync   <= r_bit_meta;
      r_bit_q      <= r_bit_sync;
      r_level_prev <= w_level;
      r_capture    <= w_level & ~r_level_prev;
    end
  end

`ifdef SERIAL_LOADER_DEBOUNCE_EN
  localparam int unsigned DbW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  logic [DbW-1:0] r_db_cnt;

  // Level rises once the synchronised strobe has been high DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db_cnt <= '0;
    end else if (!r_strb_sync) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt != DbLast) begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_level = r_strb_sync && (r_db_cnt == DbLast);
`else
  logic w_unused_db;
  assign w_unused_db = ^DEBOUNCE_CYCLES;
  assign w_level     = r_strb_sync;
`endif

  assign o_capture = r_capture;
  assign o_bit     = r_bit_q;

endmodule

// File: rtl/serial_digit_loader.sv
// Assembles a 4-bit digit MSB-first from a strobed serial input and holds it for the decoder.
// Strobe debounce is compiled in when SERIAL_LOADER_DEBOUNCE_EN is defined.
module serial_digit_loader
  import serial_digit_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_bit_in,
  input  logic                   i_bit_strobe,
  input  logic                   i_clear,
  output logic                   o_a,
  output logic                   o_b,
  output logic                   o_c,
  output logic                   o_d,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic [BIT_COUNT_W-1:0] o_bit_count,
  output logic                   o_aborted
);

  localparam int unsigned HoldW = cnt_w(HOLD_CYCLES);
  localparam int unsigned ToW   = cnt_w(TIMEOUT_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_COUNT_W-1:0] LastBit = BIT_COUNT_W'(NIBBLE_W - 1);
  localparam logic [BIT_COUNT_W-1:0] FullCnt = BIT_COUNT_W'(NIBBLE_W);

  logic w_capture;
  logic w_bit;

  strobe_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_strobe_conditioner (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_bit_strobe(i_bit_strobe),
    .i_bit_in    (i_bit_in),
    .o_capture   (w_capture),
    .o_bit       (w_bit)
  );

  loader_state_t           r_state, w_state_next;
  logic [NIBBLE_W-1:0]     r_shift, w_shift_next;
  logic [NIBBLE_W-1:0]     r_digit, w_digit_next;
  logic [BIT_COUNT_W-1:0]  r_bit_count, w_bit_count_next;
  logic [ToW-1:0]          r_to_cnt, w_to_cnt_next;
  logic [HoldW-1:0]        r_hold_cnt, w_hold_cnt_next;
  logic                    r_aborted, w_aborted_next;
  logic [NIBBLE_W-1:0]     w_shifted;

  assign w_shifted = {r_shift[NIBBLE_W-2:0], w_bit};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_digit     <= '0;
      r_bit_count <= '0;
      r_to_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_digit     <= w_digit_next;
      r_bit_count <= w_bit_count_next;
      r_to_cnt    <= w_to_cnt_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_aborted   <= w_aborted_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_digit_next     = r_digit;
    w_bit_count_next = r_bit_count;
    w_to_cnt_next    = r_to_cnt;
    w_hold_cnt_next  = r_hold_cnt;
    w_aborted_next   = 1'b0;

    if (i_clear) begin
      // Clear outranks a same-cycle capture and never reports an abort.
      w_state_next     = IDLE;
      w_shift_next     = '0;
      w_digit_next     = '0;
      w_bit_count_next = '0;
      w_to_cnt_next    = '0;
      w_hold_cnt_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            w_shift_next     = {{(NIBBLE_W-1){1'b0}}, w_bit};
            w_bit_count_next = BIT_COUNT_W'(1);
            w_to_cnt_next    = '0;
            w_state_next     = SHIFT;
          end
        end
        SHIFT: begin
          if (w_capture) begin
            w_shift_next  = w_shifted;
            w_to_cnt_next = '0;
            if (r_bit_count == LastBit) begin
              w_digit_next     = w_shifted;
              w_bit_count_next = FullCnt;
              w_hold_cnt_next  = '0;
              w_state_next     = HOLD;
            end else begin
              w_bit_count_next = r_bit_count + 1'b1;
            end
          end else if (r_to_cnt == ToLast) begin
            w_aborted_next   = 1'b1;
            w_bit_count_next = '0;
            w_state_next     = IDLE;
          end else begin
            w_to_cnt_next = r_to_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (r_hold_cnt == HoldLast) begin
            w_bit_count_next = '0;
            w_state_next     = IDLE;
          end else begin
            w_hold_cnt_next = r_hold_cnt + 1'b1;
          end
        end
        default: begin
          w_bit_count_next = '0;
          w_state_next     = IDLE;
        end
      endcase
    end
  end

  assign {o_a, o_b, o_c, o_d} = r_digit;
  assign o_ready              = (r_state == HOLD);
  assign o_busy               = (r_state == SHIFT);
  assign o_bit_count          = r_bit_count;
  assign o_aborted            = r_aborted;

endmodule

// File: tb/tb_serial_digit_loader.sv
// Directed self-checking bench for serial_digit_loader (with or without strobe debounce).
module tb_serial_digit_loader;

`ifdef SERIAL_LOADER_DEBOUNCE_EN
  localparam int unsigned DB    = 16;
  localparam int unsigned HOLD  = 40;
  localparam int unsigned HIGH  = 20;
  localparam int unsigned SHORT = 20;
  localparam int unsigned LAT   = 4 + DB - 1;
`else
  localparam int unsigned DB    = 16;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned HIGH  = 5;
  localparam int unsigned SHORT = 1;
  localparam int unsigned LAT   = 4;
`endif
  localparam int unsigned TIMEOUT   = 1000;
  localparam int unsigned GAP       = 5;
  localparam int unsigned ABORT_IDX = TIMEOUT - (HIGH + GAP - LAT);

  logic       clk;
  logic       reset_n;
  logic       bit_in;
  logic       bit_strobe;
  logic       clear;
  logic       a, b, c, d;
  logic       ready;
  logic       busy;
  logic [2:0] bit_count;
  logic       aborted;

  int n_cmp = 0;
  int n_err = 0;

  serial_digit_loader #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_bit_in    (bit_in),
    .i_bit_strobe(bit_strobe),
    .i_clear     (clear),
    .o_a         (a),
    .o_b         (b),
    .o_c         (c),
    .o_d         (d),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_bit_count (bit_count),
    .o_aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic bval);
    bit_in = bval;
    tick();
    bit_strobe = 1'b1;
    repeat (HIGH) tick();
    bit_strobe = 1'b0;
    repeat (GAP) tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && ready; i++) tick();
    chk("wait_idle_ready", {31'b0, ready}, 32'd0);
  endtask

  initial begin
    int n_ready;
    int n_abort;
    int first_abort;

    reset_n    = 1'b0;
    bit_in     = 1'b0;
    bit_strobe = 1'b0;
    clear      = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {24'b0, a, b, c, d, ready, busy, aborted, 1'b0}, 32'd0);
    chk("reset_bit_count", {29'b0, bit_count}, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Digit 1001 with latency and ready-window checks on the last bit.
    send_bit(1'b1);
    chk("t1_count1", {29'b0, bit_count}, 32'd1);
    chk("t1_busy1", {31'b0, busy}, 32'd1);
    send_bit(1'b0);
    chk("t1_count2", {29'b0, bit_count}, 32'd2);
    send_bit(1'b0);
    chk("t1_count3", {29'b0, bit_count}, 32'd3);
    bit_in = 1'b1;
    tick();
    bit_strobe = 1'b1;
    repeat (LAT - 1) tick();
    chk("t1_ready_early", {31'b0, ready}, 32'd0);
    tick();
    chk("t1_ready_on", {31'b0, ready}, 32'd1);
    chk("t1_digit", {28'b0, a, b, c, d}, 32'h9);
    chk("t1_busy_hold", {31'b0, busy}, 32'd0);
    chk("t1_count_hold", {29'b0, bit_count}, 32'd4);
    bit_strobe = 1'b0;
    n_ready = 1;
    for (int i = 0; i < HOLD + 20; i++) begin
      tick();
      if (!ready) break;
      n_ready++;
    end
    chk("t1_ready_cycles", n_ready, HOLD);
    chk("t1_count_idle", {29'b0, bit_count}, 32'd0);
    chk("t1_digit_held", {28'b0, a, b, c, d}, 32'h9);
    repeat (GAP) tick();

    // Out-of-range code 1010 passes through.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_idle();
    chk("t2_digit", {28'b0, a, b, c, d}, 32'hA);

    // Two bits then silence: single abort at the expected cycle, digit kept.
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t3_count2", {29'b0, bit_count}, 32'd2);
    n_abort     = 0;
    first_abort = -1;
    for (int i = 1; i <= TIMEOUT + 100; i++) begin
      tick();
      if (aborted) begin
        n_abort++;
        if (first_abort < 0) first_abort = i;
      end
    end
    chk("t3_abort_pulses", n_abort, 1);
    chk("t3_abort_cycle", first_abort, ABORT_IDX);
    chk("t3_count_after", {29'b0, bit_count}, 32'd0);
    chk("t3_busy_after", {31'b0, busy}, 32'd0);
    chk("t3_digit_kept", {28'b0, a, b, c, d}, 32'hA);

    // Clear on the same edge as the 4th capture.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t4_count3", {29'b0, bit_count}, 32'd3);
    bit_in = 1'b1;
    tick();
    bit_strobe = 1'b1;
    repeat (LAT - 1) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_ready", {31'b0, ready}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_count", {29'b0, bit_count}, 32'd0);
    chk("t4_digit", {28'b0, a, b, c, d}, 32'h0);
    chk("t4_aborted", {31'b0, aborted}, 32'd0);
    repeat (HIGH - LAT) tick();
    bit_strobe = 1'b0;
    repeat (GAP) tick();
    chk("t4_count_later", {29'b0, bit_count}, 32'd0);

    // Digit 1100 with an extra strobe landing in HOLD, then digit 0111.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bit_in = 1'b0;
    tick();
    bit_strobe = 1'b1;
    repeat (SHORT) tick();
    bit_strobe = 1'b0;
    repeat (2) tick();
    bit_in     = 1'b1;
    bit_strobe = 1'b1;
    repeat (HIGH) tick();
    bit_strobe = 1'b0;
    repeat (GAP) tick();
    wait_idle();
    chk("t5_digit_a", {28'b0, a, b, c, d}, 32'hC);
    chk("t5_count_idle", {29'b0, bit_count}, 32'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_idle();
    chk("t5_digit_b", {28'b0, a, b, c, d}, 32'h7);

    // Asynchronous reset mid-digit.
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t6_count2", {29'b0, bit_count}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_outputs", {24'b0, a, b, c, d, ready, busy, aborted, 1'b0}, 32'd0);
    chk("t6_async_count", {29'b0, bit_count}, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (GAP) tick();
    chk("t6_busy_after", {31'b0, busy}, 32'd0);

`ifdef SERIAL_LOADER_DEBOUNCE_EN
    // Short glitch is filtered; a strobe of DB+2 cycles captures exactly once.
    bit_in = 1'b1;
    tick();
    bit_strobe = 1'b1;
    repeat (5) tick();
    bit_strobe = 1'b0;
    repeat (GAP + 20) tick();
    chk("db_glitch_count", {29'b0, bit_count}, 32'd0);
    chk("db_glitch_busy", {31'b0, busy}, 32'd0);
    bit_strobe = 1'b1;
    repeat (DB + 2) tick();
    bit_strobe = 1'b0;
    repeat (10) tick();
    chk("db_long_count", {29'b0, bit_count}, 32'd1);
    chk("db_long_busy", {31'b0, busy}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
